// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU memory responder: FSM states,
// request kinds and default widths.
package cpu_mem_pkg;
   localparam int DEF_ADDR_W   = 16;
   localparam int DEF_DATA_W   = 16;
   localparam int MAX_READ_LAT = 7;
   localparam int LAT_W        = 3;

   typedef enum logic [2:0] {
      S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_WR_SETUP, S_WR_STROBE, S_RESP
   } mem_state_t;

   typedef enum logic [1:0] {KIND_IFETCH, KIND_LOAD, KIND_STORE} req_kind_t;

   // A store wins over the fetch flag, which only qualifies reads.
   function automatic req_kind_t req_kind(input logic we, input logic ifetch);
      if (we)     return KIND_STORE;
      if (ifetch) return KIND_IFETCH;
      return KIND_LOAD;
   endfunction
endpackage

// File: rtl/mem_lat_timer.sv
// Loadable 3-bit down-counter timing the RAM read latency; done flags the
// decrement that brings the count to zero.
module mem_lat_timer
   import cpu_mem_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [LAT_W-1:0] load_val,
   input  logic             dec,
   output logic             done
);
   logic [LAT_W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                 count <= '0;
      else if (load)             count <= load_val;
      else if (dec && count != 0) count <= count - 1'b1;
   end

   assign done = dec && (count == LAT_W'(1));
endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder sequencing a single-port synchronous RAM for
// fetch/load/store requests. Optional MEM_ALIGN_CHECK_EN rejects odd addresses.
module cpu_mem_responder
   import cpu_mem_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic              req_ifetch,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic              rsp_write,
   output logic              rsp_ifetch,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              busy,
   output logic [ADDR_W-2:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam logic [LAT_W-1:0] LAT = LAT_W'(READ_LAT);

   mem_state_t        state;
   req_kind_t         kind;
   logic [ADDR_W-2:0] addr_q;
   logic [DATA_W-1:0] wdata_q, rdata_q;
   logic              err_q, misalign, t_done;

`ifdef MEM_ALIGN_CHECK_EN
   assign misalign = req_addr[0];
`else
   logic unused_addr_lsb;
   assign misalign        = 1'b0;
   assign unused_addr_lsb = req_addr[0];
`endif

   mem_lat_timer u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (state == S_RD_ISSUE),
      .load_val (LAT),
      .dec      (state == S_RD_WAIT),
      .done     (t_done)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         kind      <= KIND_LOAD;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         rsp_valid <= 1'b0;
      end else begin
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         rsp_valid <= 1'b0;
         case (state)
            S_IDLE: if (req_valid) begin
               kind  <= req_kind(req_we, req_ifetch);
               err_q <= misalign;
               if (misalign) begin
                  state     <= S_RESP;
                  rsp_valid <= 1'b1;
               end else begin
                  // RAM address/data only move on a real access, so they hold otherwise.
                  addr_q <= req_addr[ADDR_W-1:1];
                  if (req_we) begin
                     wdata_q <= req_wdata;
                     state   <= S_WR_SETUP;
                  end else begin
                     mem_rd <= 1'b1;
                     state  <= S_RD_ISSUE;
                  end
               end
            end
            S_RD_ISSUE: state <= S_RD_WAIT;
            S_RD_WAIT: if (t_done) begin
               rdata_q   <= mem_rdata;
               rsp_valid <= 1'b1;
               state     <= S_RESP;
            end
            S_WR_SETUP: begin
               mem_wr <= 1'b1;
               state  <= S_WR_STROBE;
            end
            S_WR_STROBE: begin
               rsp_valid <= 1'b1;
               state     <= S_RESP;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign req_ready  = (state == S_IDLE) && !reset;
   assign busy       = (state != S_IDLE);
   assign rsp_write  = (kind == KIND_STORE);
   assign rsp_ifetch = (kind == KIND_IFETCH);
   assign rsp_err    = err_q;
   assign rsp_rdata  = (rsp_write || err_q) ? '0 : rdata_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench: one responder at READ_LAT=1 (a_*) and one at READ_LAT=3 (b_*)
// sharing a behavioural RAM.
module tb_cpu_mem_responder;
   logic clk = 1'b0, reset = 1'b1;
   always #5 clk = ~clk;

   int errors = 0, checks = 0;

   logic        a_valid = 0, a_ready, a_we = 0, a_ifetch = 0;
   logic [15:0] a_addr = 0, a_wdata = 0, a_rdata, a_mem_wdata, a_mem_rdata;
   logic        a_rsp_valid, a_rsp_write, a_rsp_ifetch, a_rsp_err, a_busy, a_mem_rd, a_mem_wr;
   logic [14:0] a_mem_addr;

   logic        b_valid = 0, b_ready, b_we = 0, b_ifetch = 0;
   logic [15:0] b_addr = 0, b_wdata = 0, b_rdata, b_mem_wdata, b_mem_rdata;
   logic        b_rsp_valid, b_rsp_write, b_rsp_ifetch, b_rsp_err, b_busy, b_mem_rd, b_mem_wr;
   logic [14:0] b_mem_addr;

   cpu_mem_responder #(.ADDR_W(16), .DATA_W(16), .READ_LAT(1)) dut_a (
      .clk(clk), .reset(reset), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
      .req_ifetch(a_ifetch), .req_addr(a_addr), .req_wdata(a_wdata), .rsp_valid(a_rsp_valid),
      .rsp_write(a_rsp_write), .rsp_ifetch(a_rsp_ifetch), .rsp_rdata(a_rdata), .rsp_err(a_rsp_err),
      .busy(a_busy), .mem_addr(a_mem_addr), .mem_rd(a_mem_rd), .mem_wr(a_mem_wr),
      .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata));

   cpu_mem_responder #(.ADDR_W(16), .DATA_W(16), .READ_LAT(3)) dut_b (
      .clk(clk), .reset(reset), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
      .req_ifetch(b_ifetch), .req_addr(b_addr), .req_wdata(b_wdata), .rsp_valid(b_rsp_valid),
      .rsp_write(b_rsp_write), .rsp_ifetch(b_rsp_ifetch), .rsp_rdata(b_rdata), .rsp_err(b_rsp_err),
      .busy(b_busy), .mem_addr(b_mem_addr), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr),
      .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata));

   // Synchronous RAM: data appears exactly READ_LAT cycles after the strobe, zero otherwise.
   logic [15:0] ram [0:32767];
   logic [15:0] a_pipe = 0;
   logic [15:0] b_pipe [0:2];
   logic        pl_en = 0;
   logic [14:0] pl_addr = 0;
   logic [15:0] pl_data = 0;

   always @(posedge clk) begin
      if (pl_en)         ram[pl_addr]    <= pl_data;
      else if (a_mem_wr) ram[a_mem_addr] <= a_mem_wdata;
      else if (b_mem_wr) ram[b_mem_addr] <= b_mem_wdata;
      a_pipe    <= a_mem_rd ? ram[a_mem_addr] : 16'h0000;
      b_pipe[0] <= b_mem_rd ? ram[b_mem_addr] : 16'h0000;
      b_pipe[1] <= b_pipe[0];
      b_pipe[2] <= b_pipe[1];
   end
   assign a_mem_rdata = a_pipe;
   assign b_mem_rdata = b_pipe[2];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [14:0] wa, input logic [15:0] wd);
      pl_en = 1; pl_addr = wa; pl_data = wd;
      step();
      pl_en = 0;
   endtask

   // Full READ_LAT=1 read on dut_a, starting in an idle cycle and ending idle.
   task automatic read_a(input string tag, input logic [15:0] addr, input logic ifetch,
                         input logic [15:0] exp);
      a_valid = 1; a_we = 0; a_ifetch = ifetch; a_addr = addr;
      chk({tag, ".ready"}, a_ready, 1);
      step(); a_valid = 0;
      chk({tag, ".rd"}, a_mem_rd, 1);
      chk({tag, ".maddr"}, a_mem_addr, addr[15:1]);
      chk({tag, ".rsp_early"}, a_rsp_valid, 0);
      step();
      chk({tag, ".rd_pulse"}, a_mem_rd, 0);
      chk({tag, ".rsp_early2"}, a_rsp_valid, 0);
      step();
      chk({tag, ".rsp"}, a_rsp_valid, 1);
      chk({tag, ".rdata"}, a_rdata, exp);
      chk({tag, ".ifetch"}, a_rsp_ifetch, ifetch);
      chk({tag, ".write"}, a_rsp_write, 0);
      chk({tag, ".err"}, a_rsp_err, 0);
      chk({tag, ".rd_none"}, a_mem_rd, 0);
      step();
      chk({tag, ".rsp_pulse"}, a_rsp_valid, 0);
      chk({tag, ".ready_back"}, a_ready, 1);
   endtask

   initial begin
      // Reset with RAM preloads
      preload(15'h0008, 16'hA5C3);
      preload(15'h0001, 16'h1111);
      preload(15'h0020, 16'h5555);
      preload(15'h7FFF, 16'hBEEF);
      preload(15'h0000, 16'h0F0F);
      chk("rst.ready", a_ready, 0);
      chk("rst.busy", a_busy, 0);
      chk("rst.rsp", a_rsp_valid, 0);
      chk("rst.rd_wr", {a_mem_rd, a_mem_wr}, 0);
      chk("rst.rdata", a_rdata, 0);
      chk("rst.maddr", a_mem_addr, 0);
      reset = 0; #1;
      chk("rst.ready_after", a_ready, 1);
      chk("rst.b_ready_after", b_ready, 1);

      // Fetch word 8
      read_a("fetch10", 16'h0010, 1, 16'hA5C3);

      // Store 0x1234 to 0x0020
      a_valid = 1; a_we = 1; a_ifetch = 1; a_addr = 16'h0020; a_wdata = 16'h1234;
      step(); a_valid = 0;
      chk("st.setup_wr", a_mem_wr, 0);
      chk("st.maddr", a_mem_addr, 15'h0010);
      chk("st.wdata", a_mem_wdata, 16'h1234);
      step();
      chk("st.strobe", a_mem_wr, 1);
      chk("st.maddr_hold", a_mem_addr, 15'h0010);
      chk("st.rsp_early", a_rsp_valid, 0);
      step();
      chk("st.wr_pulse", a_mem_wr, 0);
      chk("st.rsp", a_rsp_valid, 1);
      chk("st.write", a_rsp_write, 1);
      chk("st.ifetch", a_rsp_ifetch, 0);
      chk("st.rdata", a_rdata, 0);
      step();
      chk("st.ready", a_ready, 1);
      read_a("ld20", 16'h0020, 0, 16'h1234);

      // READ_LAT=3 load with the next request held through busy
      b_valid = 1; b_addr = 16'h0002;
      chk("l3.ready", b_ready, 1);
      for (int k = 1; k <= 5; k++) begin
         step();
         chk($sformatf("l3.busy%0d", k), b_busy, 1);
         chk($sformatf("l3.ready%0d", k), b_ready, 0);
         chk($sformatf("l3.rsp%0d", k), b_rsp_valid, (k == 5));
         chk($sformatf("l3.rd%0d", k), b_mem_rd, (k == 1));
      end
      chk("l3.rdata", b_rdata, 16'h1111);
      chk("l3.kind", {b_rsp_write, b_rsp_ifetch, b_rsp_err}, 0);
      step();
      chk("l3.ready6", b_ready, 1);
      chk("l3.busy6", b_busy, 0);
      step(); b_valid = 0;
      chk("l3.accept7", b_mem_rd, 1);
      for (int k = 8; k <= 11; k++) step();
      chk("l3.rsp11", b_rsp_valid, 1);
      chk("l3.rdata11", b_rdata, 16'h1111);
      chk("l3.no_wr", b_mem_wr, 0);

      // Reset during WR_STROBE aborts the store
      a_valid = 1; a_we = 1; a_addr = 16'h0040; a_wdata = 16'hDEAD;
      step(); a_valid = 0;
      step();
      chk("rw.strobe", a_mem_wr, 1);
      #1 reset = 1;
      #1;
      chk("rw.wr_drop", a_mem_wr, 0);
      chk("rw.busy_drop", a_busy, 0);
      step();
      chk("rw.no_rsp", a_rsp_valid, 0);
      reset = 0;
      step();
      chk("rw.no_rsp2", a_rsp_valid, 0);
      chk("rw.ready", a_ready, 1);
      read_a("rw.ld40", 16'h0040, 0, 16'h5555);

      // Odd address
`ifdef MEM_ALIGN_CHECK_EN
      a_valid = 1; a_we = 0; a_ifetch = 0; a_addr = 16'h0003;
      step(); a_valid = 0;
      chk("mis.rd", a_mem_rd, 0);
      chk("mis.rsp", a_rsp_valid, 1);
      chk("mis.err", a_rsp_err, 1);
      chk("mis.rdata", a_rdata, 0);
      step();
      chk("mis.ready", a_ready, 1);
      chk("mis.rsp_pulse", a_rsp_valid, 0);
`else
      read_a("odd03", 16'h0003, 0, 16'h1111);
`endif

      // Back-to-back fetches across the top of the address space
      read_a("wrapFFFE", 16'hFFFE, 1, 16'hBEEF);
      read_a("wrap0000", 16'h0000, 1, 16'h0F0F);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the processor's fetch/load/store requests.
- Sits between the opcode decoder/datapath (initiator) and a single-port synchronous RAM.
- Accepts one request at a time: instruction fetch, data load, or data store.
- Sequences the RAM, returns read data or a write acknowledge as a one-cycle response pulse, and exposes busy so the control FSM can stall.

Parameters:
- ADDR_W, 16, byte address width; RAM is addressed by word as addr[ADDR_W-1:1].
- DATA_W, 16, data word width.
- READ_LAT, 1, RAM read latency in cycles from mem_rd to valid mem_rdata; legal range 1..7.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept; transfer occurs when req_valid && req_ready.
- req_we  input  1  1 = store, 0 = read.
- req_ifetch  input  1  1 = instruction fetch, 0 = data access; ignored when req_we=1.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  DATA_W  store data.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_write  output  1  response is a store acknowledge.
- rsp_ifetch  output  1  response is an instruction fetch.
- rsp_rdata  output  DATA_W  read data; 0 for store acknowledges.
- rsp_err  output  1  misaligned access; see Optional Feature.
- busy  output  1  request in flight (state != IDLE).
- mem_addr  output  ADDR_W-1  RAM word address.
- mem_rd  output  1  RAM read strobe.
- mem_wr  output  1  RAM write enable.
- mem_wdata  output  DATA_W  RAM write data.
- mem_rdata  input  DATA_W  RAM read data, valid READ_LAT cycles after mem_rd.

Behaviour:
- Reset (asynchronous): state=IDLE, latency counter=0.
  - All outputs 0 except req_ready=1 once reset deasserts.
  - Reset during any state aborts the access: mem_wr and mem_rd drop immediately, no rsp_valid is issued.
- States: IDLE, RD_ISSUE, RD_WAIT, WR_SETUP, WR_STROBE, RESP.
- Capture: req_ready=1 only in IDLE. On acceptance in cycle T, addr, wdata, we and ifetch are registered.
- Read path (accept at T):
  - T+1 RD_ISSUE: mem_rd=1, mem_addr=addr[ADDR_W-1:1]; counter loads READ_LAT.
  - RD_WAIT decrements the counter each cycle. When it reaches 0, mem_rdata is captured.
  - RESP at T+2+READ_LAT: rsp_valid=1, rsp_rdata=captured data, rsp_ifetch=registered ifetch.
- Write path (accept at T):
  - T+1 WR_SETUP: mem_addr and mem_wdata are driven, mem_wr=0.
  - T+2 WR_STROBE: mem_wr=1, addr and data held stable.
  - T+3 RESP: rsp_valid=1, rsp_write=1.
- RESP always returns to IDLE the next cycle. req_ready rises in the cycle after RESP; minimum spacing between accepts is load READ_LAT+3 cycles, store 4 cycles.
- mem_addr and mem_wdata hold their last value when unused; mem_rd and mem_wr are single-cycle pulses.
- No response backpressure: the initiator must sample rsp_* in the RESP cycle.
- req_valid while busy is ignored (not queued). The initiator holds its request until req_ready.
- Registered read data is held until the next read's RESP.
- Address wrap: address 0xFFFE maps to word 0x7FFF; there is no wrap logic.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: an accepted request with req_addr[0]=1 performs no RAM access. The FSM goes IDLE→RESP, giving rsp_valid at T+1 with rsp_err=1, rsp_rdata=0, and rsp_write/rsp_ifetch reflecting the request.
- Not defined: req_addr[0] is ignored, rsp_err is tied 0, and the RESP-direct transition is absent.

Decomposition:
- Package cpu_mem_pkg:
  - state enum mem_state_t;
  - request-kind typedef (IFETCH/LOAD/STORE);
  - default ADDR_W/DATA_W constants;
  - MAX_READ_LAT=7.
- Sub-module mem_lat_timer: loadable down-counter, 3 bits, with a done flag. Instantiated once for RD_WAIT.

Test Plan:
- Reset, then fetch from addr 0x0010, READ_LAT=1, RAM word 8=0xA5C3 → mem_rd at T+1 with mem_addr=0x0008; rsp_valid at T+3, rsp_rdata=0xA5C3, rsp_ifetch=1.
- Store 0x1234 to 0x0020 → mem_wr only at T+2 with mem_addr=0x0010, mem_wdata=0x1234; rsp_valid and rsp_write at T+3; a following load of 0x0020 returns 0x1234.
- READ_LAT=3, load from 0x0002 → busy for 5 cycles; rsp_valid at T+5; req_valid held during busy is accepted only at T+6.
- Assert reset during WR_STROBE → mem_wr falls asynchronously; no rsp_valid; RAM word unchanged on the next read.
- MEM_ALIGN_CHECK_EN defined, load from 0x0003 → no mem_rd; rsp_valid and rsp_err at T+1, rsp_rdata=0. Undefined: the same stimulus reads word 0x0001.
- Back-to-back fetches to 0xFFFE and 0x0000 → mem_addr 0x7FFF then 0x0000, correct data on both, no spurious pulses.
